// File: rtl/vpu_spram_arbiter.sv
// vpu_spram_arbiter: shares the single-port sprite/BG-parameter RAM between the VPU loader (strict priority)
// and the CPU bus. Build macro VPU_SPRAM_VBLANK_LOCK_EN restricts CPU accesses to vblank (vsync=0).
module vpu_spram_arbiter #(
   parameter int unsigned ADDR_W       = 10,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned STARVE_LIMIT = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              vpu_en,
   input  logic [ADDR_W-1:0] vpu_addr,
   output logic [DATA_W-1:0] vpu_dout,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout,
   input  logic              vsync,
   output logic              starve_err
);

   localparam int unsigned     CNT_W   = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      ACK     = 2'd2
   } state_t;

   state_t             r_state;
   logic               r_cpu_ack;
   logic [DATA_W-1:0]  r_cpu_rdata;
   logic               r_starve;
   logic [CNT_W-1:0]   r_wait;

   logic w_lock_ok;
   logic w_cpu_pend;
   logic w_cpu_issue;
   logic w_wait_inc;
   logic w_wait_hit;

`ifdef VPU_SPRAM_VBLANK_LOCK_EN
   assign w_lock_ok = ~vsync;
`else
   logic w_unused_vsync;
   assign w_unused_vsync = vsync;
   assign w_lock_ok      = 1'b1;
`endif

   // CPU may only issue from IDLE; gated by rst_n so nothing reaches the RAM while held in reset
   assign w_cpu_pend  = rst_n & (r_state == IDLE) & cpu_req;
   assign w_cpu_issue = w_cpu_pend & ~vpu_en & w_lock_ok;
   assign w_wait_inc  = w_cpu_pend & ~w_cpu_issue;
   assign w_wait_hit  = w_wait_inc & (r_wait >= (CNT_MAX - CNT_W'(1)));

   // RAM port mux: VPU always wins, CPU takes the remaining IDLE cycles
   always_comb begin
      ram_en   = 1'b0;
      ram_we   = 1'b0;
      ram_addr = cpu_addr;
      ram_din  = cpu_wdata;
      if (vpu_en) begin
         ram_en   = 1'b1;
         ram_addr = vpu_addr;
      end else if (w_cpu_issue) begin
         ram_en = 1'b1;
         ram_we = cpu_we;
      end
   end

   // CPU transaction FSM with registered ack and read data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cpu_ack   <= 1'b0;
         r_cpu_rdata <= '0;
      end else begin
         r_cpu_ack <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_cpu_issue) begin
                  r_state   <= cpu_we ? ACK : RD_WAIT;
                  r_cpu_ack <= cpu_we;
               end
            end
            RD_WAIT: begin
               r_cpu_rdata <= ram_dout;
               r_cpu_ack   <= 1'b1;
               r_state     <= ACK;
            end
            ACK: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Starvation monitor: saturating count of blocked IDLE cycles, sticky error flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wait   <= '0;
         r_starve <= 1'b0;
      end else begin
         if (w_cpu_issue) begin
            r_wait <= '0;
         end else if (w_wait_inc && (r_wait != CNT_MAX)) begin
            r_wait <= r_wait + CNT_W'(1);
         end
         if (w_wait_hit) begin
            r_starve <= 1'b1;
         end
      end
   end

   assign vpu_dout   = ram_dout;
   assign cpu_ack    = r_cpu_ack;
   assign cpu_rdata  = r_cpu_rdata;
   assign starve_err = r_starve;

endmodule

// File: tb/tb_vpu_spram_arbiter.sv
// Self-checking bench for vpu_spram_arbiter: transaction-level model + RAM model + directed vectors.
module tb_vpu_spram_arbiter;

   localparam int unsigned AW    = 10;
   localparam int unsigned DW    = 32;
   localparam int unsigned LIMIT = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          vpu_en;
   logic [AW-1:0] vpu_addr;
   logic [DW-1:0] vpu_dout;
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_ack;
   logic [DW-1:0] cpu_rdata;
   logic          ram_en;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout;
   logic          vsync;
   logic          starve_err;

   int n_chk  = 0;
   int n_fail = 0;

   logic [DW-1:0] mem [0:1023];
   logic [DW-1:0] sm  [0:1023];

   always #5 clk = ~clk;

   vpu_spram_arbiter #(
      .ADDR_W      (AW),
      .DATA_W      (DW),
      .STARVE_LIMIT(LIMIT)
   ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .vpu_en    (vpu_en),
      .vpu_addr  (vpu_addr),
      .vpu_dout  (vpu_dout),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_ack   (cpu_ack),
      .cpu_rdata (cpu_rdata),
      .ram_en    (ram_en),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_din   (ram_din),
      .ram_dout  (ram_dout),
      .vsync     (vsync),
      .starve_err(starve_err)
   );

   function automatic logic [DW-1:0] pat(input int i);
      return 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0003);
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Synchronous-read RAM macro, 1-cycle latency
   initial begin
      for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
      ram_dout <= '0;
   end
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_din;
         else        ram_dout      <= mem[ram_addr];
      end
   end

   // Transaction-level model: idle window, ack due cycle, shadow memory, wait count
   initial begin
      int            cyc;
      int            busy_until;
      int            ack_cyc;
      bit            ack_rd;
      bit            prev_vpu;
      bit            idle;
      bit            issue;
      bit            lock_ok;
      int            m_wait;
      bit            m_starve;
      logic [AW-1:0] prev_va;
      logic [DW-1:0] pend_rd;
      logic [DW-1:0] m_rdata;
      for (int i = 0; i < 1024; i++) sm[i] = pat(i);
      cyc = 0; busy_until = -1; ack_cyc = -1; ack_rd = 1'b0; prev_vpu = 1'b0;
      m_wait = 0; m_starve = 1'b0; prev_va = '0; pend_rd = '0; m_rdata = '0;
      forever begin
         @(negedge clk);
         if (rst_n !== 1'b1) begin
            check("m_rst_ack", 32'(cpu_ack), 32'd0);
            check("m_rst_rdata", cpu_rdata, 32'd0);
            check("m_rst_starve", 32'(starve_err), 32'd0);
            check("m_rst_ram_we", 32'(ram_we), 32'd0);
            busy_until = -1; ack_cyc = -1; ack_rd = 1'b0; prev_vpu = 1'b0;
            m_wait = 0; m_starve = 1'b0; m_rdata = '0;
         end else begin
            idle = (cyc > busy_until);
            if (cyc == ack_cyc && ack_rd) m_rdata = pend_rd;
            lock_ok = 1'b1;
`ifdef VPU_SPRAM_VBLANK_LOCK_EN
            lock_ok = !vsync;
`endif
            issue = idle && cpu_req && !vpu_en && lock_ok;
            check("m_ram_en", 32'(ram_en), 32'(vpu_en || issue));
            check("m_ram_we", 32'(ram_we), 32'(issue && cpu_we));
            if (vpu_en)     check("m_ram_addr_vpu", 32'(ram_addr), 32'(vpu_addr));
            else if (issue) check("m_ram_addr_cpu", 32'(ram_addr), 32'(cpu_addr));
            if (issue && cpu_we) check("m_ram_din", ram_din, cpu_wdata);
            check("m_cpu_ack", 32'(cpu_ack), 32'(cyc == ack_cyc));
            check("m_cpu_rdata", cpu_rdata, m_rdata);
            check("m_starve", 32'(starve_err), 32'(m_starve));
            if (prev_vpu) check("m_vpu_dout", vpu_dout, sm[prev_va]);
            if (issue) begin
               ack_cyc    = cyc + (cpu_we ? 1 : 2);
               busy_until = ack_cyc;
               ack_rd     = !cpu_we;
               if (cpu_we) sm[cpu_addr] = cpu_wdata;
               else        pend_rd      = sm[cpu_addr];
               m_wait = 0;
            end else if (idle && cpu_req) begin
               if (m_wait < int'(LIMIT)) m_wait++;
               if (m_wait >= int'(LIMIT)) m_starve = 1'b1;
            end
            prev_vpu = vpu_en;
            prev_va  = vpu_addr;
         end
         cyc++;
      end
   end

   task automatic cpu_rd(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string nm);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
      tick();
      tick();
      #2;
      check({nm, "_ack"}, 32'(cpu_ack), 32'd1);
      check(nm, cpu_rdata, exp);
      tick();
      cpu_req = 1'b0;
   endtask

   // Directed stimulus with hand-computed expectations
   initial begin
      rst_n = 1'b0; vpu_en = 1'b0; vpu_addr = '0; cpu_req = 1'b0; cpu_we = 1'b0;
      cpu_addr = '0; cpu_wdata = '0; vsync = 1'b0;
      tick();
      #2;
      check("rst_ack", 32'(cpu_ack), 32'd0);
      check("rst_rdata", cpu_rdata, 32'd0);
      check("rst_starve", 32'(starve_err), 32'd0);
      check("rst_ram_en", 32'(ram_en), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // write 0x280, then read it back
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h280; cpu_wdata = 32'hDEAD_BEEF;
      #2;
      check("wr_ram_we", 32'(ram_we), 32'd1);
      check("wr_ram_addr", 32'(ram_addr), 32'h280);
      check("wr_ram_din", ram_din, 32'hDEAD_BEEF);
      check("wr_ack_T", 32'(cpu_ack), 32'd0);
      tick();
      cpu_req = 1'b0;
      #2;
      check("wr_ack_T1", 32'(cpu_ack), 32'd1);
      tick();
      #2;
      check("wr_ack_T2", 32'(cpu_ack), 32'd0);
      tick();
      cpu_req = 1'b1; cpu_we = 1'b0;
      #2;
      check("rd_ram_en", 32'(ram_en), 32'd1);
      check("rd_ram_we", 32'(ram_we), 32'd0);
      tick();
      #2;
      check("rd_ack_T1", 32'(cpu_ack), 32'd0);
      check("rd_no_issue_T1", 32'(ram_en), 32'd0);
      tick();
      #2;
      check("rd_ack_T2", 32'(cpu_ack), 32'd1);
      check("rd_data", cpu_rdata, 32'hDEAD_BEEF);
      check("ack_no_reissue", 32'(ram_en), 32'd0);
      tick();
      cpu_req = 1'b0;
      #2;
      check("rd_hold", cpu_rdata, 32'hDEAD_BEEF);

      // back-to-back writes with req held high: one write per 2 cycles
      tick();
      cpu_req = 1'b1; cpu_we = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cpu_addr = AW'(10'h100 + i); cpu_wdata = 32'h5A00_0000 + 32'(i);
         #2;
         check("b2b_issue", 32'(ram_we), 32'd1);
         tick();
         tick();
      end
      cpu_req = 1'b0;
      cpu_rd(10'h101, 32'h5A00_0001, "b2b_rd");

      // collision: 20 VPU cycles with a pending CPU read
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h010; vpu_en = 1'b1;
      for (int k = 0; k < 20; k++) begin
         vpu_addr = AW'(640 + k);
         #2;
         check("col_vaddr", 32'(ram_addr), 32'(640 + k));
         tick();
      end
      vpu_en = 1'b0;
      #2;
      check("col_issue_en", 32'(ram_en), 32'd1);
      check("col_issue_addr", 32'(ram_addr), 32'h010);
      check("col_starve", 32'(starve_err), 32'd1);
      tick();
      #2;
      check("col_ack21", 32'(cpu_ack), 32'd0);
      tick();
      #2;
      check("col_ack22", 32'(cpu_ack), 32'd1);
      check("col_rdata", cpu_rdata, pat(16));
      tick();
      cpu_req = 1'b0;

      // interleave: CPU read issued, VPU read in the RD_WAIT cycle
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h020;
      #2;
      check("il_issue_addr", 32'(ram_addr), 32'h020);
      tick();
      vpu_en = 1'b1; vpu_addr = 10'd645;
      #2;
      check("il_vpu_addr", 32'(ram_addr), 32'd645);
      tick();
      vpu_en = 1'b0;
      #2;
      check("il_ack", 32'(cpu_ack), 32'd1);
      check("il_rdata", cpu_rdata, pat(32));
      check("il_vpu_dout", vpu_dout, pat(645));
      tick();
      cpu_req = 1'b0;

      // starvation after reset: flag rises at cycle 8
      rst_n = 1'b0;
      #2;
      check("st_rst_clear", 32'(starve_err), 32'd0);
      tick();
      rst_n = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h300; cpu_wdata = 32'h1234_5678; vpu_en = 1'b1;
      for (int k = 0; k < 10; k++) begin
         vpu_addr = AW'(700 + k);
         #2;
         check("st_flag", 32'(starve_err), 32'(k >= 8));
         tick();
      end
      vpu_en = 1'b0;
      #2;
      check("st_issue", 32'(ram_we), 32'd1);
      tick();
      #2;
      check("st_ack", 32'(cpu_ack), 32'd1);
      tick();
      cpu_req = 1'b0;
      #2;
      check("st_sticky", 32'(starve_err), 32'd1);
      tick();
      cpu_rd(10'h300, 32'h1234_5678, "st_rd");

`ifdef VPU_SPRAM_VBLANK_LOCK_EN
      // vblank lock: no issue while vsync=1
      vsync = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h3F0; cpu_wdata = 32'hCAFE_F00D;
      for (int k = 0; k < 3; k++) begin
         #2;
         check("lk_blocked", 32'(ram_en), 32'd0);
         tick();
      end
      vsync = 1'b0;
      #2;
      check("lk_issue", 32'(ram_we), 32'd1);
      tick();
      #2;
      check("lk_ack", 32'(cpu_ack), 32'd1);
      tick();
      cpu_req = 1'b0;
`else
      // vsync has no effect without the lock
      vsync = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h3F0; cpu_wdata = 32'hCAFE_F00D;
      #2;
      check("nolk_issue", 32'(ram_we), 32'd1);
      tick();
      #2;
      check("nolk_ack", 32'(cpu_ack), 32'd1);
      tick();
      cpu_req = 1'b0; vsync = 1'b0;
`endif

      // reset in RD_WAIT: ack/rdata clear at once, held req reissued afterwards
      tick();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h280;
      tick();
      rst_n = 1'b0;
      #1;
      check("mr_ack", 32'(cpu_ack), 32'd0);
      check("mr_rdata", cpu_rdata, 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      #2;
      check("mr_reissue_en", 32'(ram_en), 32'd1);
      check("mr_reissue_addr", 32'(ram_addr), 32'h280);
      tick();
      tick();
      #2;
      check("mr_ack2", 32'(cpu_ack), 32'd1);
      check("mr_rdata2", cpu_rdata, 32'hDEAD_BEEF);
      tick();
      cpu_req = 1'b0;
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
